// File: rtl/multi_pwm_receiver.sv
// Multi-channel PWM receiver: measures each channel's high time in microseconds, clamps accepted
// widths into a value range and drops to a failsafe value when a channel goes quiet.
//
// state    | meaning
// WAIT_LOW | input not yet seen low; a pulse already in progress is never measured
// IDLE     | input low, waiting for a rising edge
// MEASURE  | input high, width counter running on us_tick
module multi_pwm_receiver #(
    parameter int N_CH         = 7,
    parameter int N_VAL        = 14,
    parameter int TICKS_PER_US = 38,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000,
    parameter int GLITCH_US    = 800,
    parameter int MAX_VALID_US = 2200,
    parameter int TIMEOUT_US   = 100000,
    parameter int FAILSAFE_VAL = 0
) (
    input  logic                    sys_clk,
    input  logic                    resetn,
    input  logic [N_CH-1:0]         pwm_in,
    output logic [N_CH*N_VAL-1:0]   val_out,
    output logic [N_CH-1:0]         val_valid,
    output logic [N_CH-1:0]         val_stb,
    output logic [N_CH-1:0]         err_stb
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int WW = $clog2(MAX_VALID_US + 2);
    localparam int TW = $clog2(TIMEOUT_US + 1);

    localparam logic [PW-1:0]    PRESC_LAST  = PW'(TICKS_PER_US - 1);
    localparam logic [WW-1:0]    GLITCH_W    = WW'(GLITCH_US);
    localparam logic [WW-1:0]    MAX_VALID_W = WW'(MAX_VALID_US);
    localparam logic [WW-1:0]    SAT_W       = WW'(MAX_VALID_US + 1);
    localparam logic [WW-1:0]    MIN_W       = WW'(MIN_US);
    localparam logic [WW-1:0]    MAX_W       = WW'(MAX_US);
    localparam logic [TW-1:0]    TO_LAST     = TW'(TIMEOUT_US - 1);
    localparam logic [TW-1:0]    TO_MAX      = TW'(TIMEOUT_US);
    localparam logic [N_VAL-1:0] FS_VAL      = N_VAL'(FAILSAFE_VAL);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2
    } state_t;

    logic [PW-1:0]   presc_q, presc_d;
    logic            us_tick;
    logic [1:0]      prime_q, prime_d;
    logic            primed;
    logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [N_CH-1:0] rise_q, rise_d, fall_q, fall_d;

    // primed holds off WAIT_LOW until the reset-cleared synchronizer chain reflects the real input
    always_comb begin
        us_tick = (presc_q == PRESC_LAST);
        presc_d = us_tick ? '0 : presc_q + PW'(1);
        primed  = (prime_q == 2'd3);
        prime_d = primed ? prime_q : prime_q + 2'd1;
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise_d  = sync2_q & ~sync3_q;
        fall_d  = ~sync2_q & sync3_q;
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            prime_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            presc_q <= presc_d;
            prime_q <= prime_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [WW-1:0]    width_q, width_d;
        logic [TW-1:0]    tout_q, tout_d;
        logic [N_VAL-1:0] val_q, val_d;
        logic             valid_q, valid_d;
        logic             stb_q, stb_d;
        logic             err_q, err_d;
        logic             meas_done, sat_hit, reject, accept, expire;
        logic [WW-1:0]    clamped;
        logic [N_VAL-1:0] val_new;

        assign meas_done = (state_q == MEASURE) && fall_q[i];
        assign sat_hit   = (state_q == MEASURE) && !fall_q[i] && us_tick && (width_q == MAX_VALID_W);
        assign reject    = meas_done && ((width_q < GLITCH_W) || (width_q > MAX_VALID_W));
        assign accept    = meas_done && !reject;
        assign expire    = us_tick && (tout_q == TO_LAST);

        always_ff @(posedge sys_clk or negedge resetn) begin
            if (!resetn) state_q <= WAIT_LOW;
            else         state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                WAIT_LOW: if (primed && !sync3_q[i]) state_d = IDLE;
                IDLE:     if (rise_q[i]) state_d = MEASURE;
                MEASURE: begin
                    if (fall_q[i])    state_d = IDLE;
                    else if (sat_hit) state_d = WAIT_LOW;
                end
                default:  state_d = WAIT_LOW;
            endcase
        end

        always_comb begin
            if (width_q < MIN_W)      clamped = MIN_W;
            else if (width_q > MAX_W) clamped = MAX_W;
            else                      clamped = width_q;
            val_new = N_VAL'(clamped - MIN_W);

            width_d = width_q;
            tout_d  = tout_q;
            val_d   = val_q;
            valid_d = valid_q;
            stb_d   = accept;
            err_d   = reject || sat_hit;
            case (state_q)
                IDLE:    width_d = '0;
                MEASURE: if (us_tick && width_q != SAT_W) width_d = width_q + WW'(1);
                default: ;
            endcase
            if (accept)                          tout_d = '0;
            else if (us_tick && tout_q != TO_MAX) tout_d = tout_q + TW'(1);
            // an accepted pulse wins over a timeout expiring on the same edge
            if (accept) begin
                val_d   = val_new;
                valid_d = 1'b1;
            end else if (expire) begin
                val_d   = FS_VAL;
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge sys_clk or negedge resetn) begin
            if (!resetn) begin
                width_q <= '0;
                tout_q  <= '0;
                val_q   <= FS_VAL;
                valid_q <= 1'b0;
                stb_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                width_q <= width_d;
                tout_q  <= tout_d;
                val_q   <= val_d;
                valid_q <= valid_d;
                stb_q   <= stb_d;
                err_q   <= err_d;
            end
        end

        assign val_out[i*N_VAL +: N_VAL] = val_q;
        assign val_valid[i]              = valid_q;
        assign val_stb[i]                = stb_q;
        assign err_stb[i]                = err_q;
    end

endmodule
